// File: rtl/sme_pkg.sv
// Shared types and constants for the SME share sequencers.
// SME_SHARE_SEQ_CLEAR_EN adds the CLR state to the state enum.
package sme_pkg;
  localparam int SME_RF_AW = 4;
  localparam int SME_SMAX  = 3;
  localparam int SME_SBW   = $clog2(SME_SMAX);

  typedef logic [SME_SBW-1:0] sme_bank_t;

`ifdef SME_SHARE_SEQ_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RAND, ST_FINAL, ST_CLR} sme_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RAND, ST_FINAL} sme_state_t;
`endif
endpackage

// File: rtl/sme_share_acc.sv
// XOR accumulator plus share-bank down-counter used by the share sequencers.
module sme_share_acc #(
  parameter  int XLEN = 32,
  parameter  int SMAX = 3,
  localparam int SBW  = $clog2(SMAX)
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            load,
  input  logic [XLEN-1:0] load_val,
  input  logic            step,
  input  logic [XLEN-1:0] step_val,
  output logic [XLEN-1:0] acc,
  output logic [SBW-1:0]  cnt
);

  // load restarts the counter at the top bank; step folds in a word and moves down one bank
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= load_val;
      cnt <= SBW'(SMAX-1);
    end else if (step) begin
      acc <= acc ^ step_val;
      cnt <= cnt - SBW'(1);
    end
  end

endmodule

// File: rtl/sme_share_seq.sv
// Splits one XLEN value into SMAX Boolean shares, writing one share bank per cycle.
// SME_SHARE_SEQ_CLEAR_EN enables the zeroing (CLR) sequence selected by req_clear.
module sme_share_seq
  import sme_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int SMAX = SME_SMAX,
  localparam int SBW  = $clog2(SMAX)
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  output logic                 g_clk_req,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SME_RF_AW-1:0] req_addr,
  input  logic [XLEN-1:0]      req_data,
  input  logic                 req_clear,
  output logic                 rng_req,
  input  logic                 rng_valid,
  input  logic [XLEN-1:0]      rng_data,
  output logic                 rf_wen,
  output logic [SBW-1:0]       rf_bank,
  output logic [SME_RF_AW-1:0] rf_addr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 busy
);

  sme_state_t           state_q, state_d;
  logic [SME_RF_AW-1:0] addr_q;
  logic [XLEN-1:0]      acc;
  logic [SBW-1:0]       cnt;
  logic                 acc_load, acc_step;
  logic [XLEN-1:0]      step_val;

`ifndef SME_SHARE_SEQ_CLEAR_EN
  logic unused_clear;
  assign unused_clear = req_clear;
`endif

  sme_share_acc #(.XLEN(XLEN), .SMAX(SMAX)) u_acc (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .load     (acc_load),
    .load_val (req_data),
    .step     (acc_step),
    .step_val (step_val),
    .acc      (acc),
    .cnt      (cnt)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc_load) addr_q <= req_addr;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rng_req   = 1'b0;
    rf_wen    = 1'b0;
    rf_bank   = '0;
    rf_addr   = '0;
    rf_wdata  = '0;
    acc_load  = 1'b0;
    acc_step  = 1'b0;
    step_val  = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          acc_load = 1'b1;
`ifdef SME_SHARE_SEQ_CLEAR_EN
          state_d  = req_clear ? ST_CLR : ST_RAND;
`else
          state_d  = ST_RAND;
`endif
        end
      end
      // random shares go to banks SMAX-1..1; a missing RNG word stalls everything
      ST_RAND: begin
        rng_req  = 1'b1;
        rf_bank  = cnt;
        rf_addr  = addr_q;
        rf_wdata = rng_data;
        if (rng_valid) begin
          rf_wen   = 1'b1;
          acc_step = 1'b1;
          step_val = rng_data;
          if (cnt == SBW'(1)) state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        rf_wen   = 1'b1;
        rf_addr  = addr_q;
        rf_wdata = acc;
        state_d  = ST_IDLE;
      end
`ifdef SME_SHARE_SEQ_CLEAR_EN
      ST_CLR: begin
        rf_wen  = 1'b1;
        rf_bank = cnt;
        rf_addr = addr_q;
        if (cnt == '0) state_d  = ST_IDLE;
        else           acc_step = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign g_clk_req = busy | req_valid;

endmodule
